// File: rtl/z16_ctrl_fsm_if.sv
// z16_ctrl_fsm_if: request/ready handshake between the control FSM and the shared memory
interface z16_ctrl_fsm_if;
    logic o_mem_req;
    logic o_mem_we;
    logic o_addr_sel;
    logic i_mem_ready;

    modport master (
        output o_mem_req,
        output o_mem_we,
        output o_addr_sel,
        input  i_mem_ready
    );

    modport slave (
        input  o_mem_req,
        input  o_mem_we,
        input  o_addr_sel,
        output i_mem_ready
    );
endinterface

// File: rtl/z16_ctrl_fsm.sv
// z16_ctrl_fsm: multi-cycle Z16 control FSM sharing one memory port between fetch and load/store
module z16_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    input  logic [3:0]        i_opcode,
    input  logic              i_branch_taken,
    z16_ctrl_fsm_if.master    mem,
    output logic              o_ir_we,
    output logic              o_pc_we,
    output logic [1:0]        o_pc_sel,
    output logic              o_rd_wen,
    output logic [1:0]        o_wb_sel,
    output logic [2:0]        o_state,
    output logic              o_busy,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_instret
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;
    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [2:0]       w_after;
    logic [3:0]       r_op;
    logic [WD_W-1:0]  r_wd;
    logic [CNT_W-1:0] r_instret;
    logic             w_rdy;
    logic             w_load;
    logic             w_store;
    logic             w_jump;
    logic             w_branch;
    logic             w_wait;
    logic             w_timeout;
    logic             w_retire;

    assign w_rdy     = mem.i_mem_ready;
    assign w_load    = r_op == 4'hA;
    assign w_store   = r_op == 4'hB;
    assign w_jump    = r_op[3:1] == 3'b110;
    assign w_branch  = r_op[3:1] == 3'b111;
    assign w_wait    = (r_state == S_FETCH || r_state == S_MEM) && !w_rdy;
    assign w_timeout = w_wait && (r_wd == WD_W'(MEM_TIMEOUT - 1));
    assign w_retire  = (r_state == S_EXEC && w_branch)
                     || (r_state == S_MEM && w_store && w_rdy)
                     || r_state == S_WB;
    // i_run only matters at an instruction boundary
    assign w_after   = i_run ? S_FETCH : S_IDLE;

    // next state; a ready in the last watchdog cycle takes priority over the timeout
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = w_after;
            S_FETCH:  w_next = w_rdy ? S_DECODE : w_timeout ? S_ERR : S_FETCH;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = w_branch ? w_after : (w_load || w_store) ? S_MEM : S_WB;
            S_MEM:    w_next = !w_rdy ? (w_timeout ? S_ERR : S_MEM) : w_load ? S_WB : w_after;
            S_WB:     w_next = w_after;
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // opcode is captured once so later stages ignore decoder changes
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                 r_op <= 4'h0;
        else if (r_state == S_DECODE) r_op <= i_opcode;
    end

    // watchdog restarts on every state change and counts unanswered request cycles
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)               r_wd <= '0;
        else if (w_next != r_state) r_wd <= '0;
        else if (w_wait)            r_wd <= r_wd + 1'b1;
    end

    // retired-instruction counter, wraps naturally
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)      r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + 1'b1;
    end

    assign mem.o_mem_req  = r_state == S_FETCH || r_state == S_MEM;
    assign mem.o_mem_we   = r_state == S_MEM && w_store;
    assign mem.o_addr_sel = r_state == S_MEM;
    assign o_ir_we        = r_state == S_FETCH && w_rdy;
    // every PC update is the final act of an instruction
    assign o_pc_we        = w_retire;
    assign o_pc_sel       = (r_state == S_EXEC && w_branch) ? {1'b0, i_branch_taken}
                          : (r_state == S_WB && w_jump)     ? (r_op[0] ? 2'd2 : 2'd1)
                          : 2'd0;
    assign o_rd_wen       = r_state == S_WB;
    assign o_wb_sel       = r_state != S_WB ? 2'd0 : w_load ? 2'd1 : w_jump ? 2'd2 : 2'd0;
    assign o_state        = r_state;
    assign o_busy         = r_state != S_IDLE && r_state != S_ERR;
    assign o_err          = r_state == S_ERR;
    assign o_instret      = r_instret;
endmodule

// File: tb/tb_z16_ctrl_fsm.sv
// tb_z16_ctrl_fsm: directed plus random instruction streams checked against a per-instruction phase model
module tb_z16_ctrl_fsm;
    localparam int TMO = 4;
    localparam int CW  = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_run = 1'b0;
    logic [3:0]    i_opcode = 4'h0;
    logic          i_branch_taken = 1'b0;
    logic          o_ir_we;
    logic          o_pc_we;
    logic [1:0]    o_pc_sel;
    logic          o_rd_wen;
    logic [1:0]    o_wb_sel;
    logic [2:0]    o_state;
    logic          o_busy;
    logic          o_err;
    logic [CW-1:0] o_instret;

    int n_assert = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    string g_step = "reset";

    z16_ctrl_fsm_if mem_if ();

    z16_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_run          (i_run),
        .i_opcode       (i_opcode),
        .i_branch_taken (i_branch_taken),
        .mem            (mem_if),
        .o_ir_we        (o_ir_we),
        .o_pc_we        (o_pc_we),
        .o_pc_sel       (o_pc_sel),
        .o_rd_wen       (o_rd_wen),
        .o_wb_sel       (o_wb_sel),
        .o_state        (o_state),
        .o_busy         (o_busy),
        .o_err          (o_err),
        .o_instret      (o_instret)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", g_step, tag, obs, exp);
        end
    endtask

    // inputs are already driven; check this cycle's outputs, then move past the next edge
    task automatic expect_cycle(input int st, input int req, input int we, input int asel,
                                input int irwe, input int pcwe, input int pcsel,
                                input int rdw, input int wbs, input int ret);
        #2;
        chk("state",    32'(o_state),           st);
        chk("mem_req",  32'(mem_if.o_mem_req),  req);
        chk("mem_we",   32'(mem_if.o_mem_we),   we);
        chk("addr_sel", 32'(mem_if.o_addr_sel), asel);
        chk("ir_we",    32'(o_ir_we),           irwe);
        chk("pc_we",    32'(o_pc_we),           pcwe);
        chk("pc_sel",   32'(o_pc_sel),          pcsel);
        chk("rd_wen",   32'(o_rd_wen),          rdw);
        chk("wb_sel",   32'(o_wb_sel),          wbs);
        chk("busy",     32'(o_busy),            (st >= 1 && st <= 5) ? 1 : 0);
        chk("err",      32'(o_err),             (st == 6) ? 1 : 0);
        chk("instret",  32'(o_instret),         exp_cnt);
        @(posedge i_clk);
        #1;
        if (ret != 0) exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    // from IDLE: stay idle for n cycles, then request a run and land in FETCH
    task automatic idle_to_fetch(input int n);
        i_run = 1'b0;
        for (int k = 0; k < n; k++) expect_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        i_run = 1'b1;
        expect_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // one whole instruction starting in FETCH; the expected phases follow from the opcode class
    task automatic do_instr(input logic [3:0] op, input logic tk, input int fw, input int mw,
                            input logic keep);
        logic ld, st, br, jp;
        int pcs, wbs;
        ld = op == 4'hA;
        st = op == 4'hB;
        br = op >= 4'hE;
        jp = op == 4'hC || op == 4'hD;
        pcs = op == 4'hC ? 1 : op == 4'hD ? 2 : 0;
        wbs = ld ? 1 : jp ? 2 : 0;
        i_opcode = op;
        for (int k = 0; k <= fw; k++) begin
            mem_if.i_mem_ready = (k == fw);
            i_run = 1'($urandom);
            i_branch_taken = 1'($urandom);
            expect_cycle(1, 1, 0, 0, k == fw, 0, 0, 0, 0, 0);
        end
        mem_if.i_mem_ready = 1'($urandom);
        i_run = 1'($urandom);
        expect_cycle(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        i_opcode = 4'($urandom);
        mem_if.i_mem_ready = 1'($urandom);
        i_branch_taken = tk;
        i_run = br ? keep : 1'($urandom);
        expect_cycle(3, 0, 0, 0, 0, br, br ? 32'(tk) : 0, 0, 0, br);
        i_branch_taken = 1'($urandom);
        if (ld || st) begin
            for (int k = 0; k <= mw; k++) begin
                mem_if.i_mem_ready = (k == mw);
                i_run = (st && k == mw) ? keep : 1'($urandom);
                expect_cycle(4, 1, st, 1, 0, st && k == mw, 0, 0, 0, st && k == mw);
            end
        end
        if (!br && !st) begin
            mem_if.i_mem_ready = 1'($urandom);
            i_run = keep;
            expect_cycle(5, 0, 0, 0, 0, 1, pcs, 1, wbs, 1);
        end
        if (!keep) idle_to_fetch($urandom_range(0, 2));
    endtask

    initial begin
        mem_if.i_mem_ready = 1'b0;
        do_reset();
        g_step = "after_reset";
        idle_to_fetch(2);

        g_step = "alu";
        do_instr(4'h1, 1'b0, 0, 0, 1'b1);
        g_step = "load_wait3";
        do_instr(4'hA, 1'b0, 0, 3, 1'b1);
        g_step = "branch_taken";
        do_instr(4'hE, 1'b1, 0, 0, 1'b1);
        g_step = "branch_not";
        do_instr(4'hF, 1'b0, 0, 0, 1'b1);
        g_step = "jump_c";
        do_instr(4'hC, 1'b0, 0, 0, 1'b1);
        g_step = "jump_d";
        do_instr(4'hD, 1'b0, 0, 0, 1'b1);
        g_step = "fetch_ready_last";
        do_instr(4'h5, 1'b0, TMO - 1, 0, 1'b1);
        g_step = "mem_ready_last";
        do_instr(4'hA, 1'b0, 0, TMO - 1, 1'b1);
        g_step = "store_stop";
        do_instr(4'hB, 1'b0, 0, 1, 1'b0);

        g_step = "random";
        for (int n = 0; n < 40; n++)
            do_instr(4'($urandom), 1'($urandom), $urandom_range(0, TMO - 1),
                     $urandom_range(0, TMO - 1), 1'($urandom_range(0, 3) != 0));

        g_step = "fetch_timeout";
        mem_if.i_mem_ready = 1'b0;
        for (int k = 0; k < TMO; k++) expect_cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_if.i_mem_ready = 1'b1;
        i_run = 1'b1;
        for (int k = 0; k < 3; k++) expect_cycle(6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        g_step = "err_cleared";
        idle_to_fetch(1);

        g_step = "mem_timeout";
        i_opcode = 4'hB;
        mem_if.i_mem_ready = 1'b1;
        expect_cycle(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        expect_cycle(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cycle(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_if.i_mem_ready = 1'b0;
        for (int k = 0; k < TMO; k++) expect_cycle(4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        mem_if.i_mem_ready = 1'b1;
        expect_cycle(6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        idle_to_fetch(0);

        g_step = "reset_in_mem";
        do_instr(4'h2, 1'b0, 0, 0, 1'b1);
        do_instr(4'h3, 1'b0, 0, 0, 1'b1);
        i_opcode = 4'hA;
        mem_if.i_mem_ready = 1'b1;
        expect_cycle(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        expect_cycle(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cycle(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_if.i_mem_ready = 1'b0;
        i_rst_n = 1'b0;
        expect_cycle(4, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        i_rst_n = 1'b1;
        i_run = 1'b0;
        exp_cnt = 0;
        expect_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        i_run = 1'b1;
        expect_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        g_step = "after_mid_reset";
        do_instr(4'h7, 1'b0, 0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
